// File: rtl/gpio_debounce.sv
// Per-bit switch conditioner: synchroniser chain, stability-counter debounce filter,
// optional rise/fall pulses and sticky change flags (enabled by GPIO_DEBOUNCE_EDGE_EN).
module gpio_debounce #(
  parameter int               WIDTH         = 16,
  parameter int               STABLE_CYCLES = 1000000,
  parameter int               SYNC_STAGES   = 2,
  parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] db_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] chg_o,
  input  logic [WIDTH-1:0] chg_clr_i
);

  localparam int               CNT_W   = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [CNT_W-1:0] cnt_q  [WIDTH];
  logic [CNT_W-1:0] cnt_d  [WIDTH];
  logic [WIDTH-1:0] db_q, db_d;
  logic [WIDTH-1:0] flip_d;
  logic [WIDTH-1:0] sync_s;

  always_comb begin
    sync_d[0] = raw_i;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Any cycle where the synchronised input agrees with db_o restarts that bit's count.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    db_d   = db_q;
    flip_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync_s[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          db_d[i]   = sync_s[i];
          flip_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the counter array is reset explicitly; a mid-count reset must restart the full latency.
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= RESET_VAL;
      for (int i = 0; i < WIDTH; i++)       cnt_q[i]  <= '0;
      db_q <= RESET_VAL;
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= sync_d[k];
      for (int i = 0; i < WIDTH; i++)       cnt_q[i]  <= cnt_d[i];
      db_q <= db_d;
    end
  end

  assign db_o = db_q;

`ifdef GPIO_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] chg_q,  chg_d;

  // A flip and a clear of the same bit in one cycle leaves the flag set.
  always_comb begin
    rise_d = flip_d & db_d;
    fall_d = flip_d & ~db_d;
    chg_d  = (chg_q & ~chg_clr_i) | flip_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rise_q <= '0;
      fall_q <= '0;
      chg_q  <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
      chg_q  <= chg_d;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign chg_o  = chg_q;
`else
  logic unused_edge;
  assign unused_edge = ^{chg_clr_i, flip_d};
  assign rise_o = '0;
  assign fall_o = '0;
  assign chg_o  = '0;
`endif

endmodule
